alu_unit: RTL and testbench

//  - Parameterisable integer ALU for the datapath: add, subtract, bitwise AND and OR on two WIDTH-bit operands.
//  - Produces a WIDTH-bit result plus NZCV condition flags for branch/compare logic.
//  - Result and flags are registered: one clock of latency by default.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_addsub.sv | 26 ++
 rtl/alu_unit.sv | 76 +++++++
 tb/tb_alu_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared operation encoding, flag positions and flag packing for alu_unit
package alu_pkg;

    // Operation select as carried on the control port.
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    // Bit positions inside the 4-bit {N,Z,C,V} flags vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Places the four condition bits at their fixed positions.
    function automatic logic [3:0] pack_flags(
        input logic n,
        input logic z,
        input logic cf,
        input logic v
    );
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = cf;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - shared adder/subtractor: a + (b ^ {WIDTH{sub}}) + sub with carry and overflow
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;

    // Subtraction reuses the adder: invert b and inject the +1 as the carry-in.
    always_comb begin
        b_eff   = b ^ {WIDTH{sub}};
        sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum     = sum_ext[WIDTH-1:0];
        cout    = sum_ext[WIDTH];
        // Signed overflow: both adder inputs share a sign the result does not.
        ovf     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - integer ALU with NZCV flags, registered outputs unless ALU_COMB_OUT_EN is defined
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] c,
    output logic [3:0]       flags
);

    alu_op_e          op;
    logic             sub;
    logic [WIDTH-1:0] as_sum;
    logic             as_cout;
    logic             as_ovf;
    logic [WIDTH-1:0] res_next;
    logic             c_next;
    logic             v_next;
    logic [3:0]       flags_next;

    assign op  = alu_op_e'(control);
    assign sub = (op == ALU_SUB);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (a),
        .b    (b),
        .sub  (sub),
        .sum  (as_sum),
        .cout (as_cout),
        .ovf  (as_ovf)
    );

    // Operation mux; logic ops clear C and V, N and Z always follow the result.
    always_comb begin
        res_next = '0;
        c_next   = 1'b0;
        v_next   = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                res_next = as_sum;
                c_next   = as_cout;
                v_next   = as_ovf;
            end
            ALU_AND: res_next = a & b;
            ALU_OR:  res_next = a | b;
            default: res_next = '0;
        endcase
        flags_next = pack_flags(res_next[WIDTH-1], (res_next == '0), c_next, v_next);
    end

`ifdef ALU_COMB_OUT_EN
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign c     = res_next;
    assign flags = flags_next;
`else
    // Result and flags load together every edge so they can never be skewed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c     <= '0;
            flags <= '0;
        end else begin
            c     <= res_next;
            flags <= flags_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - directed and randomized checks of alu_unit against an arithmetic reference model
module tb_alu_unit;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  control;
    logic [31:0] c;
    logic [3:0]  flags;

    int          checks;
    int          errors;
    logic [31:0] prev_c;
    logic [3:0]  prev_f;

    alu_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .control (control),
        .c       (c),
        .flags   (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned/signed arithmetic on wide integers.
    function automatic void model(input logic [1:0] op, input logic [31:0] ai, input logic [31:0] bi,
                                  output logic [31:0] r, output logic [3:0] f);
        logic [63:0] wide;
        longint      sa;
        longint      sb;
        longint      s;
        logic        cf;
        logic        vf;
        sa = longint'($signed(ai));
        sb = longint'($signed(bi));
        cf = 1'b0;
        vf = 1'b0;
        case (op)
            2'd0: begin
                wide = 64'(ai) + 64'(bi);
                r    = wide[31:0];
                cf   = (wide > 64'hFFFF_FFFF);
                s    = sa + sb;
                vf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'd1: begin
                r  = ai - bi;
                cf = (ai >= bi);
                s  = sa - sb;
                vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'd2:    r = ai & bi;
            default: r = ai | bi;
        endcase
        f = {r[31], (r == 32'd0), cf, vf};
    endfunction

    function automatic void check_c(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s c got %h want %h", tag, got, exp);
        end
    endfunction

    function automatic void check_f(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s flags got %b want %b", tag, got, exp);
        end
    endfunction

    // Called at posedge+1: drive, confirm outputs still hold, then check one edge later.
    task automatic step(input string tag, input logic [1:0] op, input logic [31:0] ai,
                        input logic [31:0] bi, input logic [31:0] ec, input logic [3:0] ef);
        control = op;
        a       = ai;
        b       = bi;
        #1;
        check_c({tag, "_hold"}, c, prev_c);
        check_f({tag, "_hold"}, flags, prev_f);
        @(posedge clk);
        #1;
        check_c(tag, c, ec);
        check_f(tag, flags, ef);
        prev_c = ec;
        prev_f = ef;
    endtask

    task automatic step_model(input string tag, input logic [1:0] op, input logic [31:0] ai,
                              input logic [31:0] bi);
        logic [31:0] r;
        logic [3:0]  f;
        model(op, ai, bi, r, f);
        step(tag, op, ai, bi, r, f);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corner [5];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        a       = '0;
        b       = '0;
        control = 2'b00;
        prev_c  = '0;
        prev_f  = '0;

        #1;
        check_c("reset_init", c, 32'h0);
        check_f("reset_init", flags, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b1;

        step("add_ovf",   2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
        step("add_wrap",  2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
        step("sub_eq",    2'b01, 32'd5,         32'd5,         32'h0000_0000, 4'b0110);
        step("sub_neg",   2'b01, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b1000);
        step("sub_ovf",   2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011);
        step("and",       2'b10, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000);
        step("or",        2'b11, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 4'b1000);

        // Asynchronous reset mid-cycle while a nonzero result is held.
        #2;
        reset = 1'b0;
        #1;
        check_c("reset_async", c, 32'h0);
        check_f("reset_async", flags, 4'b0000);
        @(posedge clk);
        #1;
        check_c("reset_held", c, 32'h0);
        check_f("reset_held", flags, 4'b0000);
        reset  = 1'b1;
        prev_c = '0;
        prev_f = '0;

        // Back-to-back operations, one per cycle.
        step_model("b2b_add", 2'b00, 32'h1234_5678, 32'h8765_4321);
        step_model("b2b_sub", 2'b01, 32'h0000_0010, 32'h0000_0020);
        step_model("b2b_and", 2'b10, 32'hDEAD_BEEF, 32'hFFFF_0000);
        step_model("b2b_or",  2'b11, 32'h0000_0000, 32'h0000_0000);

        for (int i = 0; i < 300; i++) begin
            logic [1:0] rop;
            rop = 2'($urandom_range(0, 3));
            step_model("rand", rop, pick_operand(), pick_operand());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
